pdm_decimator: RTL and testbench

//  Receive side of the 1-bit PDM audio link: turns a PDM bitstream (e.g. mic/loopback on uio_in)

---
 rtl/pdm_decimator.sv | 161 ++++++++++++++++
 tb/tb_pdm_decimator.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pdm_decimator.sv
// Order-3 CIC (sinc^3) decimator: 1-bit PDM stream in, signed 16-bit PCM out.
// Integrators run at bit rate, combs run once per DECIM consumed bits.
module pdm_decimator #(
    parameter int DECIM   = 64,
    parameter bit SYNC_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pdm_en,
    input  logic        pdm_in,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    output logic        primed
);

    localparam int LOG2D = $clog2(DECIM);
    localparam int W     = 3 * LOG2D + 1;
    // Scale so that y = DECIM^3 lands on +32768 (then saturates) and y = 0 on -32768.
    localparam int unsigned RSH = (W >= 17) ? W - 17 : 0;
    localparam int unsigned LSH = (W < 17) ? 17 - W : 0;

    localparam logic [W-1:0]          OFFSET = {2'b01, {(W-2){1'b0}}};
    localparam logic signed [W+1:0]   SAT_HI = (W+2)'(32767);
    localparam logic signed [W+1:0]   SAT_LO = (W+2)'(-32768);

    logic pdm_bit;

    generate
        if (SYNC_EN) begin : g_sync
            logic [1:0] sync_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[0], pdm_in};
                end
            end
            assign pdm_bit = sync_q[1];
        end else begin : g_nosync
            assign pdm_bit = pdm_in;
        end
    endgenerate

    logic [W-1:0]     i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
    logic [LOG2D-1:0] dcnt_q, dcnt_d;
    logic             tick_q, tick_d;
    logic [W-1:0]     d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic [W-1:0]     y_q, y_d;
    logic             comb_vld_q, comb_vld_d;
    logic [1:0]       prime_cnt_q, prime_cnt_d;
    logic             primed_q, primed_d;
    logic [15:0]      sample_q, sample_d;
    logic             valid_q, valid_d;

    logic [W-1:0]        x;
    logic [W-1:0]        c1, c2, c3;
    logic [W-1:0]        diff;
    logic signed [W+1:0] diff_ext, scaled;
    logic [15:0]         sat_val;

    assign x = {{(W-1){1'b0}}, pdm_bit};

    // Integrators and decimation counter: everything holds while pdm_en is low.
    always_comb begin
        i1_d   = i1_q;
        i2_d   = i2_q;
        i3_d   = i3_q;
        dcnt_d = dcnt_q;
        tick_d = 1'b0;
        if (pdm_en) begin
            i1_d   = i1_q + x;
            i2_d   = i2_q + i1_q;
            i3_d   = i3_q + i2_q;
            dcnt_d = dcnt_q + 1'b1;
            tick_d = (dcnt_q == '1);
        end
    end

    assign c1 = i3_q - d1_q;
    assign c2 = c1 - d2_q;
    assign c3 = c2 - d3_q;

    always_comb begin
        d1_d        = d1_q;
        d2_d        = d2_q;
        d3_d        = d3_q;
        y_d         = y_q;
        comb_vld_d  = tick_q;
        prime_cnt_d = prime_cnt_q;
        primed_d    = primed_q;
        if (tick_q) begin
            d1_d = i3_q;
            d2_d = c1;
            d3_d = c2;
            y_d  = c3;
            if (prime_cnt_q != 2'd3) begin
                prime_cnt_d = prime_cnt_q + 2'd1;
            end else begin
                primed_d = 1'b1;
            end
        end
    end

    // Offset-remove, scale, saturate.
    always_comb begin
        diff     = y_q - OFFSET;
        diff_ext = {{2{diff[W-1]}}, diff};
        scaled   = (diff_ext <<< LSH) >>> RSH;
        if (scaled > SAT_HI) begin
            sat_val = 16'h7FFF;
        end else if (scaled < SAT_LO) begin
            sat_val = 16'h8000;
        end else begin
            sat_val = scaled[15:0];
        end
    end

    always_comb begin
        valid_d  = comb_vld_q && primed_q;
        sample_d = valid_d ? sat_val : sample_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1_q        <= '0;
            i2_q        <= '0;
            i3_q        <= '0;
            dcnt_q      <= '0;
            tick_q      <= 1'b0;
            d1_q        <= '0;
            d2_q        <= '0;
            d3_q        <= '0;
            y_q         <= '0;
            comb_vld_q  <= 1'b0;
            prime_cnt_q <= '0;
            primed_q    <= 1'b0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
        end else begin
            i1_q        <= i1_d;
            i2_q        <= i2_d;
            i3_q        <= i3_d;
            dcnt_q      <= dcnt_d;
            tick_q      <= tick_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            d3_q        <= d3_d;
            y_q         <= y_d;
            comb_vld_q  <= comb_vld_d;
            prime_cnt_q <= prime_cnt_d;
            primed_q    <= primed_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
        end
    end

    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign primed       = primed_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// Directed bench for pdm_decimator (DECIM=64, synchroniser on): full-scale,
// mid-scale and 75% patterns, half-rate strobe with pause, and mid-frame reset.
module tb_pdm_decimator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pdm_en = 1'b0;
    logic        pdm_in = 1'b0;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        primed;

    pdm_decimator #(.DECIM(64), .SYNC_EN(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pdm_en       (pdm_en),
        .pdm_in       (pdm_in),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .primed       (primed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [3:0]  pat;
    int          patlen;
    int          idx;
    int          cyc;
    bit          alt_en;
    bit          en_ph;
    logic [15:0] exp_val;
    int          nval, first_cyc, min_gap, max_gap, badval, early, prev_valid_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        pdm_en = 1'b0;
        pdm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n          = 1'b1;
        cyc            = 0;
        idx            = 0;
        en_ph          = 1'b0;
        prev_valid_cyc = -1;
    endtask

    task automatic clr_stats();
        nval      = 0;
        first_cyc = -1;
        min_gap   = 1 << 30;
        max_gap   = 0;
        badval    = 0;
        early     = 0;
    endtask

    // One clock: drive inputs, clock, sample 1 time unit after the edge.
    task automatic step(input bit hold);
        bit en;
        int gap;
        en     = hold ? 1'b0 : (alt_en ? ~en_ph : 1'b1);
        pdm_en = en;
        pdm_in = pat[idx];
        @(posedge clk);
        #1;
        cyc++;
        if (!hold) en_ph = ~en_ph;
        if (en) idx = (idx + 1) % patlen;
        if (sample_valid) begin
            nval++;
            if (first_cyc < 0) first_cyc = cyc;
            if (prev_valid_cyc >= 0) begin
                gap = cyc - prev_valid_cyc;
                if (gap < min_gap) min_gap = gap;
                if (gap > max_gap) max_gap = gap;
            end
            prev_valid_cyc = cyc;
            if (sample_out !== exp_val) badval++;
            if (!primed) early++;
        end
    endtask

    task automatic run(input int n, input bit hold);
        for (int k = 0; k < n; k++) step(hold);
    endtask

    // Static pattern, strobe every clock: 5 valids at cycles 258..514.
    task automatic static_case(input string tag, input logic [3:0] p, input int len,
                               input logic [15:0] ev);
        pat = p; patlen = len; alt_en = 1'b0; exp_val = ev;
        do_reset();
        clr_stats();
        run(514, 1'b0);
        check({tag, " nval"}, nval, 5);
        check({tag, " first"}, first_cyc, 258);
        check({tag, " badval"}, badval, 0);
        check({tag, " out"}, sample_out, ev);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        pat = 4'hF; patlen = 1; idx = 0; alt_en = 1'b0; en_ph = 1'b0;
        exp_val = 16'h0; prev_valid_cyc = -1;
        clr_stats();

        // Reset state
        @(posedge clk);
        #1;
        check("rst out", sample_out, 16'h0000);
        check("rst valid", sample_valid, 1'b0);
        check("rst primed", primed, 1'b0);

        // All ones: priming then 7FFF every 64 clk
        pat = 4'hF; patlen = 1; alt_en = 1'b0; exp_val = 16'h7FFF;
        do_reset();
        clr_stats();
        run(256, 1'b0);
        check("ones nvalid prime", nval, 0);
        check("ones primed early", primed, 1'b0);
        run(258, 1'b0);
        check("ones first", first_cyc, 258);
        check("ones nval", nval, 5);
        check("ones gapmin", min_gap, 64);
        check("ones gapmax", max_gap, 64);
        check("ones badval", badval, 0);
        check("ones early", early, 0);
        check("ones primed", primed, 1'b1);
        check("ones out", sample_out, 16'h7FFF);

        static_case("zeros", 4'h0, 1, 16'h8000);
        static_case("alt", 4'b0101, 2, 16'h0000);
        static_case("p75", 4'b0111, 4, 16'h4000);

        // Half-rate strobe, then a 500-clk pause mid-frame
        pat = 4'hF; patlen = 1; alt_en = 1'b1; exp_val = 16'h7FFF;
        do_reset();
        clr_stats();
        run(1200, 1'b0);
        check("half first", first_cyc, 513);
        check("half nval", nval, 6);
        check("half gapmin", min_gap, 128);
        check("half gapmax", max_gap, 128);
        check("half badval", badval, 0);
        run(40, 1'b0);
        clr_stats();
        run(500, 1'b1);
        check("pause nval", nval, 0);
        check("pause out", sample_out, 16'h7FFF);
        check("pause primed", primed, 1'b1);
        clr_stats();
        run(200, 1'b0);
        check("resume first", first_cyc, 1781);
        check("resume nval", nval, 2);
        check("resume gapmax", max_gap, 628);
        check("resume gapmin", min_gap, 128);
        check("resume badval", badval, 0);

        // Mid-frame asynchronous reset (dcnt=30, primed)
        pat = 4'hF; patlen = 1; alt_en = 1'b0; exp_val = 16'h7FFF;
        do_reset();
        clr_stats();
        run(514, 1'b0);
        run(28, 1'b0);
        check("mid primed", primed, 1'b1);
        check("mid out", sample_out, 16'h7FFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst out", sample_out, 16'h0000);
        check("arst valid", sample_valid, 1'b0);
        check("arst primed", primed, 1'b0);
        do_reset();
        clr_stats();
        run(514, 1'b0);
        check("rerun first", first_cyc, 258);
        check("rerun nval", nval, 5);
        check("rerun early", early, 0);
        check("rerun out", sample_out, 16'h7FFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
